alu_operand_stage: RTL

//  ID/EX pipeline register feeding the ALU: captures one decoded instruction per handshake,

---
 rtl/alu_operand_stage_pkg.sv | 46 ++++
 rtl/alu_fwd_mux.sv | 39 +++
 rtl/alu_operand_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: widths, operand-select codes, ALU codes, payload.
// Select codes are also used by decode, so both sides agree on the operand encodings.
// Pure declarations; no logic, no latency.
package alu_operand_stage_pkg;

   // Datapath width of the core.
   localparam int XLEN   = 32;
   localparam int RADDR_W = 5;
   localparam int OP_W    = 4;

   // Operand 0 source select, as produced by decode.
   typedef enum logic [1:0] {
      SRC0_RS1  = 2'b00,
      SRC0_PC   = 2'b01,
      SRC0_ZERO = 2'b10,
      SRC0_RSVD = 2'b11
   } src0_sel_e;

   // Operand 1 source select, as produced by decode.
   typedef enum logic [1:0] {
      SRC1_RS2  = 2'b00,
      SRC1_IMM  = 2'b01,
      SRC1_FOUR = 2'b10,
      SRC1_RSVD = 2'b11
   } src1_sel_e;

   // A few ALU operation codes; this stage passes the code through untouched.
   localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
   localparam logic [OP_W-1:0] ALU_AND = 4'd2;
   localparam logic [OP_W-1:0] ALU_OR  = 4'd3;

   // Link-address increment for JAL/JALR; zero-extended to full width.
   localparam logic [XLEN-1:0] CONST_FOUR = {{(XLEN-3){1'b0}}, 3'b100};

   // Everything held in the ID/EX register and presented to the ALU.
   typedef struct packed {
      logic [XLEN-1:0]    in_0;
      logic [XLEN-1:0]    in_1;
      logic [OP_W-1:0]    operation;
      logic [XLEN-1:0]    store_data;
      logic [RADDR_W-1:0] rd_addr;
      logic               reg_write;
   } ex_payload_t;

endpackage

// File: rtl/alu_fwd_mux.sv
// Resolves one source register value: x0 -> 0, else EX/MEM hit, else MEM/WB hit, else register file.
// Purely combinational, zero latency.
// No handshake; the caller decides when the resolved value is captured.
module alu_fwd_mux
   import alu_operand_stage_pkg::*;
(
   input  logic [RADDR_W-1:0] i_rs_addr,
   input  logic [XLEN-1:0]    i_rf_data,
   input  logic               i_ex_valid,
   input  logic [RADDR_W-1:0] i_ex_rd,
   input  logic [XLEN-1:0]    i_ex_data,
   input  logic               i_mem_valid,
   input  logic [RADDR_W-1:0] i_mem_rd,
   input  logic [XLEN-1:0]    i_mem_data,
   output logic [XLEN-1:0]    o_value
);

   logic w_rs_is_x0;
   logic w_ex_hit;
   logic w_mem_hit;

   // x0 reads as zero even if a stale forward names it, so it never matches.
   assign w_rs_is_x0 = (i_rs_addr == '0);
   assign w_ex_hit   = i_ex_valid  & (i_ex_rd  == i_rs_addr) & ~w_rs_is_x0;
   assign w_mem_hit  = i_mem_valid & (i_mem_rd == i_rs_addr) & ~w_rs_is_x0;

   // Youngest producer wins: EX/MEM is newer than MEM/WB, which is newer than the register file.
   always_comb begin
      o_value = i_rf_data;
      if (w_rs_is_x0) begin
         o_value = '0;
      end else if (w_ex_hit) begin
         o_value = i_ex_data;
      end else if (w_mem_hit) begin
         o_value = i_mem_data;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register: forwards rs1/rs2, selects ALU operands, holds one instruction for the ALU.
// Latency 1 cycle (capture edge -> out_*), full throughput while out_ready stays high.
// Backpressure: in_ready = !out_valid | out_ready; stalled outputs are held bit-stable; flush discards.
module alu_operand_stage
   import alu_operand_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [RADDR_W-1:0]  in_rs1_addr,
   input  logic [RADDR_W-1:0]  in_rs2_addr,
   input  logic [XLEN-1:0]     in_rs1_data,
   input  logic [XLEN-1:0]     in_rs2_data,
   input  logic [XLEN-1:0]     in_imm,
   input  logic [1:0]          in_src0_sel,
   input  logic [1:0]          in_src1_sel,
   input  logic [OP_W-1:0]     in_operation,
   input  logic [RADDR_W-1:0]  in_rd_addr,
   input  logic                in_reg_write,
   input  logic                fwd_ex_valid,
   input  logic [RADDR_W-1:0]  fwd_ex_rd,
   input  logic [XLEN-1:0]     fwd_ex_data,
   input  logic                fwd_mem_valid,
   input  logic [RADDR_W-1:0]  fwd_mem_rd,
   input  logic [XLEN-1:0]     fwd_mem_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     in_0,
   output logic [XLEN-1:0]     in_1,
   output logic [OP_W-1:0]     operation,
   output logic [XLEN-1:0]     out_store_data,
   output logic [RADDR_W-1:0]  out_rd_addr,
   output logic                out_reg_write
);

   logic              r_out_valid;
   ex_payload_t       r_payload;

   logic [XLEN-1:0]   w_rs1_val;
   logic [XLEN-1:0]   w_rs2_val;
   logic [XLEN-1:0]   w_op0;
   logic [XLEN-1:0]   w_op1;
   logic              w_in_ready;
   logic              w_capture;
   ex_payload_t       w_next;

   alu_fwd_mux u_fwd_rs1 (
      .i_rs_addr   (in_rs1_addr),
      .i_rf_data   (in_rs1_data),
      .i_ex_valid  (fwd_ex_valid),
      .i_ex_rd     (fwd_ex_rd),
      .i_ex_data   (fwd_ex_data),
      .i_mem_valid (fwd_mem_valid),
      .i_mem_rd    (fwd_mem_rd),
      .i_mem_data  (fwd_mem_data),
      .o_value     (w_rs1_val)
   );

   alu_fwd_mux u_fwd_rs2 (
      .i_rs_addr   (in_rs2_addr),
      .i_rf_data   (in_rs2_data),
      .i_ex_valid  (fwd_ex_valid),
      .i_ex_rd     (fwd_ex_rd),
      .i_ex_data   (fwd_ex_data),
      .i_mem_valid (fwd_mem_valid),
      .i_mem_rd    (fwd_mem_rd),
      .i_mem_data  (fwd_mem_data),
      .o_value     (w_rs2_val)
   );

   // Operand 0 select after forwarding; the reserved code reads as zero.
   always_comb begin
      w_op0 = '0;
      case (src0_sel_e'(in_src0_sel))
         SRC0_RS1:  w_op0 = w_rs1_val;
         SRC0_PC:   w_op0 = in_pc;
         SRC0_ZERO: w_op0 = '0;
         default:   w_op0 = '0;
      endcase
   end

   // Operand 1 select after forwarding; the reserved code reads as zero.
   always_comb begin
      w_op1 = '0;
      case (src1_sel_e'(in_src1_sel))
         SRC1_RS2:  w_op1 = w_rs2_val;
         SRC1_IMM:  w_op1 = in_imm;
         SRC1_FOUR: w_op1 = CONST_FOUR;
         default:   w_op1 = '0;
      endcase
   end

   // Store data is always the forwarded rs2, independent of operand 1's select.
   always_comb begin
      w_next            = '0;
      w_next.in_0       = w_op0;
      w_next.in_1       = w_op1;
      w_next.operation  = in_operation;
      w_next.store_data = w_rs2_val;
      w_next.rd_addr    = in_rd_addr;
      w_next.reg_write  = in_reg_write;
   end

   // The slot is free when empty or when its occupant leaves this cycle.
   assign w_in_ready = ~r_out_valid | out_ready;
   assign w_capture  = in_valid & w_in_ready;

   // Pipeline register: reset beats flush, flush beats capture, capture beats drain/hold.
   // Flush only kills valid and writeback; the data fields keep their last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_payload   <= '0;
      end else if (flush) begin
         r_out_valid         <= 1'b0;
         r_payload.reg_write <= 1'b0;
      end else if (w_capture) begin
         r_out_valid <= 1'b1;
         r_payload   <= w_next;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready       = w_in_ready;
   assign out_valid      = r_out_valid;
   assign in_0           = r_payload.in_0;
   assign in_1           = r_payload.in_1;
   assign operation      = r_payload.operation;
   assign out_store_data = r_payload.store_data;
   assign out_rd_addr    = r_payload.rd_addr;
   assign out_reg_write  = r_payload.reg_write;

endmodule
